arp_recv: RTL

ARP_RECV -- requirements
Module: arp_recv

---
 rtl/eth_pkg.sv | 27 ++
 rtl/arp_recv.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Package : eth_pkg
// | Ethernet/ARP field constants shared by the ARP receive and transmit paths.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;

  typedef enum logic [15:0] {
    ARP_OP_REQUEST = 16'h0001,
    ARP_OP_REPLY   = 16'h0002
  } arp_oper_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [5:0] PREAMBLE_MAX  = 6'd7;
  localparam logic [5:0] HDR_LAST_BYTE = 6'd41;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/arp_recv.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module  : arp_recv
// | Parses a GMII byte stream and flags ARP requests/replies aimed at SELF_IP.
// | Rev 1.0 - initial release
// +----------------------------------------------------------------------------
module arp_recv
  import eth_pkg::*;
#(
  parameter logic [47:0] SELF_MAC = 48'h0023543C471B,
  parameter logic [31:0] SELF_IP  = 32'h0A000021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_data_vl,
  output logic        o_arp_req,
  output logic        o_arp_resp,
  output logic [47:0] o_sha,
  output logic [31:0] o_spa
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_DROP     = 3'd4
  } state_e;

  localparam logic [15:0] c_op_req = 16'(ARP_OP_REQUEST);
  localparam logic [15:0] c_op_rep = 16'(ARP_OP_REPLY);

  state_e      r_state;
  state_e      w_state_next;
  logic [5:0]  r_cnt;
  logic        r_reject;
  logic        r_not_bcast;
  logic        r_not_self;
  logic        r_is_reply;
  logic [47:0] r_sha_cap;
  logic [31:0] r_spa_cap;

  logic [7:0]  w_mac_byte;
  logic [7:0]  w_ip_byte;
  logic        w_bcast_miss;
  logic        w_self_miss;
  logic        w_mismatch;
  logic        w_last;
  logic        w_accept;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_data_vl) begin
          if (i_data == PREAMBLE_BYTE) w_state_next = ST_PREAMBLE;
          else if (i_data == SFD_BYTE) w_state_next = ST_HEADER;
          else                         w_state_next = ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!i_data_vl)                                         w_state_next = ST_IDLE;
        else if (i_data == PREAMBLE_BYTE && r_cnt < PREAMBLE_MAX) w_state_next = ST_PREAMBLE;
        else if (i_data == SFD_BYTE)                            w_state_next = ST_HEADER;
        else                                                    w_state_next = ST_DROP;
      end
      ST_HEADER: begin
        if (!i_data_vl)  w_state_next = ST_IDLE;
        else if (w_last) w_state_next = ST_WAIT_END;
      end
      ST_WAIT_END, ST_DROP: begin
        if (!i_data_vl) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Field checks indexed by header byte position; DST may be broadcast or ours.
  always_comb begin
    w_mac_byte = 8'h00;
    case (r_cnt)
      6'd0: w_mac_byte = SELF_MAC[47:40];
      6'd1: w_mac_byte = SELF_MAC[39:32];
      6'd2: w_mac_byte = SELF_MAC[31:24];
      6'd3: w_mac_byte = SELF_MAC[23:16];
      6'd4: w_mac_byte = SELF_MAC[15:8];
      6'd5: w_mac_byte = SELF_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
    w_ip_byte = 8'h00;
    case (r_cnt)
      6'd38: w_ip_byte = SELF_IP[31:24];
      6'd39: w_ip_byte = SELF_IP[23:16];
      6'd40: w_ip_byte = SELF_IP[15:8];
      6'd41: w_ip_byte = SELF_IP[7:0];
      default: w_ip_byte = 8'h00;
    endcase
    w_bcast_miss = r_not_bcast | (i_data != 8'hFF);
    w_self_miss  = r_not_self  | (i_data != w_mac_byte);
    w_mismatch   = 1'b0;
    case (r_cnt)
      6'd5:  w_mismatch = w_bcast_miss & w_self_miss;
      6'd12: w_mismatch = (i_data != ETHERTYPE_ARP[15:8]);
      6'd13: w_mismatch = (i_data != ETHERTYPE_ARP[7:0]);
      6'd14: w_mismatch = (i_data != ARP_HTYPE_ETH[15:8]);
      6'd15: w_mismatch = (i_data != ARP_HTYPE_ETH[7:0]);
      6'd16: w_mismatch = (i_data != ARP_PTYPE_IPV4[15:8]);
      6'd17: w_mismatch = (i_data != ARP_PTYPE_IPV4[7:0]);
      6'd18: w_mismatch = (i_data != ARP_HLEN_ETH);
      6'd19: w_mismatch = (i_data != ARP_PLEN_IPV4);
      6'd20: w_mismatch = (i_data != c_op_req[15:8]);
      6'd21: w_mismatch = (i_data != c_op_req[7:0]) && (i_data != c_op_rep[7:0]);
      6'd38, 6'd39, 6'd40, 6'd41: w_mismatch = (i_data != w_ip_byte);
      default: w_mismatch = 1'b0;
    endcase
    w_last   = (r_state == ST_HEADER) && i_data_vl && (r_cnt == HDR_LAST_BYTE);
    w_accept = w_last && !(r_reject || w_mismatch);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 6'd0;
      r_reject    <= 1'b0;
      r_not_bcast <= 1'b0;
      r_not_self  <= 1'b0;
      r_is_reply  <= 1'b0;
      r_sha_cap   <= 48'h0;
      r_spa_cap   <= 32'h0;
      o_arp_req   <= 1'b0;
      o_arp_resp  <= 1'b0;
      o_sha       <= 48'h0;
      o_spa       <= 32'h0;
    end else begin
      o_arp_req  <= 1'b0;
      o_arp_resp <= 1'b0;
      if (r_state == ST_HEADER) begin
        if (i_data_vl) begin
          if (r_cnt != 6'h3F) r_cnt <= r_cnt + 6'd1;
          r_reject <= r_reject | w_mismatch;
          if (r_cnt < 6'd6) begin
            r_not_bcast <= w_bcast_miss;
            r_not_self  <= w_self_miss;
          end
          if (r_cnt == 6'd21) r_is_reply <= (i_data == c_op_rep[7:0]);
          if (r_cnt >= 6'd22 && r_cnt <= 6'd27) r_sha_cap <= {r_sha_cap[39:0], i_data};
          if (r_cnt >= 6'd28 && r_cnt <= 6'd31) r_spa_cap <= {r_spa_cap[23:0], i_data};
          if (w_accept) begin
            o_sha      <= r_sha_cap;
            o_spa      <= r_spa_cap;
            o_arp_req  <= !r_is_reply;
            o_arp_resp <= r_is_reply;
          end
        end
      end else begin
        // Outside the header the counter tracks preamble length; SFD clears it.
        r_reject    <= 1'b0;
        r_not_bcast <= 1'b0;
        r_not_self  <= 1'b0;
        if (r_state == ST_IDLE)
          r_cnt <= (i_data_vl && i_data == PREAMBLE_BYTE) ? 6'd1 : 6'd0;
        else if (r_state == ST_PREAMBLE && i_data_vl &&
                 i_data == PREAMBLE_BYTE && r_cnt < PREAMBLE_MAX)
          r_cnt <= r_cnt + 6'd1;
        else
          r_cnt <= 6'd0;
      end
    end
  end

endmodule : arp_recv
`default_nettype wire
